// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer: edge-detects the UART done flag, stores words in a
// circular FIFO and returns them through a registered 1-cycle-latency read port.
module uart_rx_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                          in_clk,
    input  logic                          in_rst,
    input  logic                          in_en,
    input  logic [DATA_WIDTH-1:0]         in_rx_data,
    input  logic                          in_rx_done,
    input  logic                          in_rd_en,
    input  logic                          in_clr_ovf,
    output logic [DATA_WIDTH-1:0]         out_data_reg,
    output logic                          out_rd_valid_reg,
    output logic                          out_empty,
    output logic                          out_full,
    output logic [$clog2(DEPTH):0]        out_count_reg,
    output logic                          out_overflow_reg
);

    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
    localparam int unsigned CNT_WIDTH  = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  done_d;

    logic wr_req_c;
    logic rd_req_c;
    logic wr_ok_c;
    logic rd_ok_c;
    logic ovf_set_c;

    assign out_empty = (out_count_reg == '0);
    assign out_full  = (out_count_reg == CNT_WIDTH'(DEPTH));

    // Request qualification; a full buffer still accepts a write if a read frees a slot.
    always_comb begin
        wr_req_c  = 1'b0;
        rd_req_c  = 1'b0;
        wr_ok_c   = 1'b0;
        rd_ok_c   = 1'b0;
        ovf_set_c = 1'b0;
        if (in_en) begin
            wr_req_c = in_rx_done & ~done_d;
            rd_req_c = in_rd_en;
        end
        rd_ok_c   = rd_req_c & ~out_empty;
        wr_ok_c   = wr_req_c & (~out_full | rd_req_c);
        ovf_set_c = wr_req_c & out_full & ~rd_req_c;
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge in_clk) begin
        if (wr_ok_c) begin
            mem[wr_ptr] <= in_rx_data;
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            done_d           <= 1'b0;
            out_count_reg    <= '0;
            out_data_reg     <= '0;
            out_rd_valid_reg <= 1'b0;
            out_overflow_reg <= 1'b0;
        end else if (in_en) begin
            done_d           <= in_rx_done;
            out_rd_valid_reg <= rd_ok_c;
            if (wr_ok_c) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_ok_c) begin
                rd_ptr       <= rd_ptr + ADDR_WIDTH'(1);
                out_data_reg <= mem[rd_ptr];
            end
            case ({wr_ok_c, rd_ok_c})
                2'b10:   out_count_reg <= out_count_reg + CNT_WIDTH'(1);
                2'b01:   out_count_reg <= out_count_reg - CNT_WIDTH'(1);
                default: out_count_reg <= out_count_reg;
            endcase
            if (ovf_set_c) begin
                out_overflow_reg <= 1'b1;
            end else if (in_clr_ovf) begin
                out_overflow_reg <= 1'b0;
            end
        end
    end

endmodule
